// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register for the 5-stage ARM core.
// It captures the decoded operands and control bits from ID and presents them
// to EXE one cycle later. It supports:
//   - hold (freeze),
//   - NOP insertion for hazards (bubble),
//   - squash on a taken branch (flush).
// Two saturating debug counters record how often bubbles and flushes were
// inserted.
module id_exe_reg #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              bubble,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       val_rn_in,
  input  logic [31:0]       val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic              imm_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        sr_in,
  output logic [31:0]       pc,
  output logic [31:0]       val_rn,
  output logic [31:0]       val_rm,
  output logic [11:0]       shift_operand,
  output logic              imm,
  output logic [23:0]       signed_imm_24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [3:0]        exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        sr,
  output logic              load_store,
  output logic              valid,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Everything the stage carries, kept together so that a NOP is simply an
  // all-zero word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic        imm;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
    logic [3:0]  sr;
    logic        load_store;
    logic        valid;
  } stage_t;

  // Per-edge action after priority resolution (flush > freeze > bubble > load).
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  localparam int                STAGE_W = $bits(stage_t);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  // Increment that sticks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  stage_t           stage_q;
  stage_t           stage_d;
  stage_t           id_s;
  act_e             act_s;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Gather the ID-stage inputs into one stage word.
  // load_store is derived here so that EXE's val2 generator gets a registered
  // select.
  always_comb begin
    id_s               = stage_t'({STAGE_W{1'b0}});
    id_s.pc            = pc_in;
    id_s.val_rn        = val_rn_in;
    id_s.val_rm        = val_rm_in;
    id_s.shift_operand = shift_operand_in;
    id_s.imm           = imm_in;
    id_s.signed_imm_24 = signed_imm_24_in;
    id_s.dest          = dest_in;
    id_s.src1          = src1_in;
    id_s.src2          = src2_in;
    id_s.exe_cmd       = exe_cmd_in;
    id_s.mem_r_en      = mem_r_en_in;
    id_s.mem_w_en      = mem_w_en_in;
    id_s.wb_en         = wb_en_in;
    id_s.b             = b_in;
    id_s.s             = s_in;
    id_s.sr            = sr_in;
    id_s.load_store    = mem_r_en_in | mem_w_en_in;
    id_s.valid         = 1'b1;
  end

  // Resolve the control inputs into a single action.
  // A flush wins even over a freeze, because the squashed instruction must not
  // survive the stall.
  always_comb begin
    if (flush) begin
      act_s = ACT_FLUSH;
    end else if (freeze) begin
      act_s = ACT_HOLD;
    end else if (bubble) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // Next-state selection for the stage word and both event counters.
  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    case (act_s)
      ACT_FLUSH: begin
        stage_d     = stage_t'({STAGE_W{1'b0}});
        flush_cnt_d = sat_inc(flush_cnt_q);
      end
      ACT_HOLD: begin
        stage_d = stage_q;
      end
      ACT_BUBBLE: begin
        stage_d      = stage_t'({STAGE_W{1'b0}});
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      ACT_LOAD: begin
        stage_d = id_s;
      end
      default: begin
        stage_d = stage_t'({STAGE_W{1'b0}});
      end
    endcase
  end

  // Stage register and counters. Reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= stage_t'({STAGE_W{1'b0}});
      bubble_cnt_q <= CNT_ZERO;
      flush_cnt_q  <= CNT_ZERO;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Every output comes straight from a flop.
  // There is no input-to-output combinational path.
  assign pc            = stage_q.pc;
  assign val_rn        = stage_q.val_rn;
  assign val_rm        = stage_q.val_rm;
  assign shift_operand = stage_q.shift_operand;
  assign imm           = stage_q.imm;
  assign signed_imm_24 = stage_q.signed_imm_24;
  assign dest          = stage_q.dest;
  assign src1          = stage_q.src1;
  assign src2          = stage_q.src2;
  assign exe_cmd       = stage_q.exe_cmd;
  assign mem_r_en      = stage_q.mem_r_en;
  assign mem_w_en      = stage_q.mem_w_en;
  assign wb_en         = stage_q.wb_en;
  assign b             = stage_q.b;
  assign s             = stage_q.s;
  assign sr            = stage_q.sr;
  assign load_store    = stage_q.load_store;
  assign valid         = stage_q.valid;
  assign bubble_cnt    = bubble_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard testbench for id_exe_reg.
// The stimulus process drives random and directed ID traffic. A
// reference model predicts the outputs after each edge and queues the
// prediction; an independent monitor pops and compares after each edge.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_id_exe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] sh;
    logic        imm;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
    logic [3:0]  sr;
  } in_t;

  typedef struct packed {
    in_t         d;
    logic        ls;
    logic        vld;
    logic [15:0] bc;
    logic [15:0] fc;
  } out_t;

  typedef struct packed {
    in_t        d;
    logic       ls;
    logic       vld;
    logic [1:0] bc;
    logic [1:0] fc;
  } out2_t;

  typedef struct packed {
    out_t       o;
    logic [1:0] bc2;
    logic [1:0] fc2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0, bubble = 1'b0, flush = 1'b0;
  logic [31:0] pc_in = 32'd0, val_rn_in = 32'd0, val_rm_in = 32'd0;
  logic [11:0] shift_operand_in = 12'd0;
  logic imm_in = 1'b0;
  logic [23:0] signed_imm_24_in = 24'd0;
  logic [3:0] dest_in = 4'd0, src1_in = 4'd0, src2_in = 4'd0, exe_cmd_in = 4'd0, sr_in = 4'd0;
  logic mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, wb_en_in = 1'b0, b_in = 1'b0, s_in = 1'b0;

  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic imm;
  logic [23:0] signed_imm_24;
  logic [3:0] dest, src1, src2, exe_cmd, sr;
  logic mem_r_en, mem_w_en, wb_en, b, s, load_store, valid;
  logic [15:0] bubble_cnt, flush_cnt;

  logic [31:0] pc2, val_rn2, val_rm2;
  logic [11:0] shift_operand2;
  logic imm2;
  logic [23:0] signed_imm_242;
  logic [3:0] dest2, src12, src22, exe_cmd2, sr2;
  logic mem_r_en2, mem_w_en2, wb_en2, b2, s2, load_store2, valid2;
  logic [1:0] bubble_cnt2, flush_cnt2;

  out_t  act;
  out2_t act2;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  out_t m_out;
  int   m_bcnt;
  int   m_fcnt;

  always #5 clk = ~clk;

  id_exe_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .bubble(bubble), .flush(flush),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .imm_in(imm_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in),
    .src2_in(src2_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .sr_in(sr_in),
    .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
    .imm(imm), .signed_imm_24(signed_imm_24), .dest(dest), .src1(src1),
    .src2(src2), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en(wb_en), .b(b), .s(s), .sr(sr), .load_store(load_store),
    .valid(valid), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .freeze(freeze), .bubble(bubble), .flush(flush),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .imm_in(imm_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in),
    .src2_in(src2_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .sr_in(sr_in),
    .pc(pc2), .val_rn(val_rn2), .val_rm(val_rm2), .shift_operand(shift_operand2),
    .imm(imm2), .signed_imm_24(signed_imm_242), .dest(dest2), .src1(src12),
    .src2(src22), .exe_cmd(exe_cmd2), .mem_r_en(mem_r_en2), .mem_w_en(mem_w_en2),
    .wb_en(wb_en2), .b(b2), .s(s2), .sr(sr2), .load_store(load_store2),
    .valid(valid2), .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2)
  );

  assign act  = {pc, val_rn, val_rm, shift_operand, imm, signed_imm_24, dest, src1, src2,
                 exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, sr, load_store, valid,
                 bubble_cnt, flush_cnt};
  assign act2 = {pc2, val_rn2, val_rm2, shift_operand2, imm2, signed_imm_242, dest2, src12,
                 src22, exe_cmd2, mem_r_en2, mem_w_en2, wb_en2, b2, s2, sr2, load_store2,
                 valid2, bubble_cnt2, flush_cnt2};

  task automatic check(input string nm, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r.pc   = $urandom;
    r.rn   = $urandom;
    r.rm   = $urandom;
    r.sh   = 12'($urandom);
    r.imm  = 1'($urandom);
    r.simm = 24'($urandom);
    r.dest = 4'($urandom);
    r.src1 = 4'($urandom);
    r.src2 = 4'($urandom);
    r.cmd  = 4'($urandom);
    r.mr   = 1'($urandom);
    r.mw   = 1'($urandom);
    r.wb   = 1'($urandom);
    r.b    = 1'($urandom);
    r.s    = 1'($urandom);
    r.sr   = 4'($urandom);
    return r;
  endfunction

  task automatic drive(input in_t x, input logic fr, input logic bu, input logic fl);
    pc_in = x.pc; val_rn_in = x.rn; val_rm_in = x.rm; shift_operand_in = x.sh;
    imm_in = x.imm; signed_imm_24_in = x.simm; dest_in = x.dest; src1_in = x.src1;
    src2_in = x.src2; exe_cmd_in = x.cmd; mem_r_en_in = x.mr; mem_w_en_in = x.mw;
    wb_en_in = x.wb; b_in = x.b; s_in = x.s; sr_in = x.sr;
    freeze = fr; bubble = bu; flush = fl;
  endtask

  // Drive one ID cycle, predict the result of the coming edge, queue it.
  task automatic apply(input in_t x, input logic fr, input logic bu, input logic fl);
    exp_t e;
    @(negedge clk);
    drive(x, fr, bu, fl);
    rst = 1'b0;
    if (fl) begin
      m_out.d = '0; m_out.ls = 1'b0; m_out.vld = 1'b0;
      m_fcnt++;
    end else if (fr) begin
      m_out = m_out;
    end else if (bu) begin
      m_out.d = '0; m_out.ls = 1'b0; m_out.vld = 1'b0;
      m_bcnt++;
    end else begin
      m_out.d = x; m_out.ls = x.mr | x.mw; m_out.vld = 1'b1;
    end
    m_out.bc = 16'(sat(m_bcnt, 65535));
    m_out.fc = 16'(sat(m_fcnt, 65535));
    e.o   = m_out;
    e.bc2 = 2'(sat(m_bcnt, 3));
    e.fc2 = 2'(sat(m_fcnt, 3));
    sbq.push_back(e);
  endtask

  // Assert reset between edges with busy inputs; outputs must clear with no clock.
  task automatic do_reset(input logic fr, input logic bu, input logic fl);
    @(negedge clk);
    drive(rand_in(), fr, bu, fl);
    rst = 1'b1;
    #1;
    check("rst_zero", 256'(act), 256'd0);
    check("rst_zero2", 256'(act2), 256'd0);
    m_out = '0; m_bcnt = 0; m_fcnt = 0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every edge compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("data", 256'(act.d), 256'(e.o.d));
        check("ctrl", 256'({act.ls, act.vld}), 256'({e.o.ls, e.o.vld}));
        check("cnt16", 256'({act.bc, act.fc}), 256'({e.o.bc, e.o.fc}));
        check("data2", 256'({act2.d, act2.ls, act2.vld}), 256'({e.o.d, e.o.ls, e.o.vld}));
        check("cnt2", 256'({act2.bc, act2.fc}), 256'({e.bc2, e.fc2}));
      end
    end
  end

  initial begin
    in_t x;
    int  r;
    logic [1:0] sat_tbl [5];
    sat_tbl[0] = 2'd1; sat_tbl[1] = 2'd2; sat_tbl[2] = 2'd3;
    sat_tbl[3] = 2'd3; sat_tbl[4] = 2'd3;
    m_out = '0; m_bcnt = 0; m_fcnt = 0;

    do_reset(1'b0, 1'b0, 1'b0);

    // Normal load of a store with a register operand.
    x = rand_in();
    x.rm = 32'd5; x.sh = 12'b001110000101; x.imm = 1'b0; x.mw = 1'b1; x.mr = 1'b0;
    apply(x, 1'b0, 1'b0, 1'b0);
    after_edge();
    check("load_val_rm", 256'(val_rm), 256'(32'd5));
    check("load_shift", 256'(shift_operand), 256'(12'h385));
    check("load_ls", 256'(load_store), 256'(1'b1));
    check("load_valid", 256'(valid), 256'(1'b1));

    // Freeze for three cycles with different inputs: everything holds.
    for (int i = 0; i < 3; i++) apply(rand_in(), 1'b1, 1'b0, 1'b0);
    after_edge();
    check("freeze_rm", 256'(val_rm), 256'(32'd5));

    // Bubble kills write-back and the destination.
    x = rand_in(); x.wb = 1'b1; x.dest = 4'd3;
    apply(x, 1'b0, 1'b1, 1'b0);
    after_edge();
    check("bub_wb", 256'(wb_en), 256'(1'b0));
    check("bub_dest", 256'(dest), 256'(4'd0));
    check("bub_valid", 256'(valid), 256'(1'b0));
    check("bub_cnt", 256'(bubble_cnt), 256'(16'd1));
    apply(rand_in(), 1'b0, 1'b0, 1'b0);

    // All three controls together: flush wins.
    apply(rand_in(), 1'b1, 1'b1, 1'b1);
    after_edge();
    check("ffb_flush_cnt", 256'(flush_cnt), 256'(16'd1));
    check("ffb_bub_cnt", 256'(bubble_cnt), 256'(16'd1));
    check("ffb_valid", 256'(valid), 256'(1'b0));

    // Saturation of the 2-bit counter.
    do_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(rand_in(), 1'b0, 1'b1, 1'b0);
      after_edge();
      check("sat_bub2", 256'(bubble_cnt2), 256'(sat_tbl[i]));
    end
    for (int i = 0; i < 5; i++) apply(rand_in(), 1'($urandom), 1'($urandom), 1'b1);

    // Random traffic, with resets landing mid-freeze and mid-flush.
    for (int i = 0; i < 400; i++) begin
      if (i == 150) begin
        apply(rand_in(), 1'b1, 1'b0, 1'b0);
        do_reset(1'b1, 1'b0, 1'b0);
      end else if (i == 300) begin
        apply(rand_in(), 1'b0, 1'b0, 1'b1);
        do_reset(1'b0, 1'b1, 1'b1);
      end
      r = int'($urandom_range(99, 0));
      apply(rand_in(), 1'(r < 25), 1'($urandom_range(99, 0) < 20), 1'(r >= 90));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- ID/EXE pipeline register of the 5-stage ARM core; feeds the EXE stage (val2 generator, ALU, branch adder).
- Captures decoded operands and control from ID each cycle.
- Supports hold (freeze), NOP-bubble insertion for hazards, and flush on taken branch.
- Derives the load_store select for val2 generation and keeps saturating bubble/flush event counters for debug.

Parameters:
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- freeze  input  1  hold all state (downstream stall)
- bubble  input  1  load a NOP instead of ID contents (hazard)
- flush  input  1  load a NOP (branch taken in EXE)
- pc_in  input  32  PC+4 of the ID instruction
- val_rn_in, val_rm_in  input  32 each  register-file read data
- shift_operand_in  input  12  instruction bits [11:0]
- imm_in  input  1  I bit
- signed_imm_24_in  input  24  branch offset
- dest_in  input  4  destination register
- src1_in, src2_in  input  4 each  source register numbers (for forwarding)
- exe_cmd_in  input  4  ALU command
- mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  input  1 each  control bits
- sr_in  input  4  status flags NZCV at decode
- pc, val_rn, val_rm, shift_operand, imm, signed_imm_24, dest, src1, src2, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, sr  output  same widths  registered copies
- load_store  output  1  registered (mem_r_en_in | mem_w_en_in); 0 for NOPs
- valid  output  1  1 = register holds a real instruction
- bubble_cnt, flush_cnt  output  CNT_W each  saturating event counts

Behaviour:
- Reset (async, rst=1): every output, including counters, is 0 immediately and held while rst=1.
- Per rising edge, priority flush > freeze > bubble > normal load.
- flush=1:
  - All data outputs are 0.
  - All control outputs (mem_r_en, mem_w_en, wb_en, b, s, load_store, valid) are 0.
  - flush_cnt increments.
  - Applies even if freeze=1.
- freeze=1 (no flush): all outputs and counters hold.
- bubble=1 (no flush/freeze): same zeroing as flush; bubble_cnt increments.
- Normal: every output takes its _in value; load_store = mem_r_en_in | mem_w_en_in; valid=1.
- Latency: exactly 1 cycle from ID inputs to outputs; no combinational path from any input to any output.
- Counters:
  - +1 per qualifying edge.
  - Saturate at 2^CNT_W-1; no wrap.
  - Held by freeze only when freeze wins, i.e. not during flush.
- flush and bubble together: counts as flush only.
- Reset asserted mid-freeze or mid-flush: outputs go to 0 asynchronously; first edge after deassert performs a normal load (subject to inputs).
- sr is captured and not modified here; status update happens in EXE.

Test Plan:
- Reset: assert rst with inputs nonzero -> all outputs and counters 0 without a clock edge; deassert -> next edge loads.
- Normal load:
  - Stimulus: val_rm_in=5, shift_operand_in=12'b001110000101, imm_in=0, mem_w_en_in=1.
  - One edge later: val_rm=5, shift_operand=12'h385, load_store=1, valid=1.
- Freeze hold: load instr A, then freeze=1 for 3 cycles with different inputs -> outputs stay A, counters unchanged.
- Bubble: bubble=1 with wb_en_in=1, dest_in=4'd3 -> wb_en=0, dest=0, valid=0, bubble_cnt=1; next normal cycle reloads.
- Flush vs freeze: flush=1, freeze=1, bubble=1 together -> NOP loaded, flush_cnt=1, bubble_cnt unchanged.
- Saturation: CNT_W=2, bubble=1 for 5 edges -> bubble_cnt = 1,2,3,3,3.
